kernel_bc_start_dispatch: RTL and testbench
===========================================

KERNEL_BC_START_DISPATCH -- requirements
Module: kernel_bc_start_dispatch

Interface
REQ-001 Parameter N_CHILD, default 2: number of downstream dataflow processes fed through start FIFOs.
REQ-002 Parameter MAX_INFLIGHT, default 4: maximum iterations issued but not yet completed.
REQ-003 Parameter CNT_WIDTH, default 3: inflight counter width; SHALL satisfy 2^CNT_WIDTH > MAX_INFLIGHT.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ap_start  input  1  upstream request to launch one iteration; held until ap_ready.
REQ-007 ap_ready  output  1  one-cycle pulse: the current iteration's start tokens are all accepted.
REQ-008 ap_done  output  1  one-cycle registered pulse per completed iteration.
REQ-009 ap_idle  output  1  high when no dispatch is in progress and the inflight count is 0.
REQ-010 start_full_n  input  N_CHILD  per-child start-FIFO not-full flag.
REQ-011 start_write  output  N_CHILD  per-child start-FIFO write strobe.
REQ-012 start_din  output  1  start-FIFO data; constant 1.
REQ-013 sink_done  input  1  one-cycle pulse from the final process per finished iteration.
REQ-014 err  output  1  sticky flag: sink_done was received while the inflight count was 0.

Function
REQ-015 Token acceptance for child i SHALL be start_write[i] & start_full_n[i] in the same cycle.
REQ-016 The FSM SHALL have two states, IDLE and DISPATCH.
REQ-017 IDLE -> DISPATCH SHALL occur when ap_start=1 and the registered inflight count is below MAX_INFLIGHT; otherwise the FSM stays in IDLE.
REQ-018 In DISPATCH, start_write[i] SHALL equal ~sent[i].
REQ-019 In IDLE, start_write SHALL be all zeros.
REQ-020 sent[i] SHALL set on acceptance for child i, so each child receives exactly one token per iteration.
REQ-021 Children stalled by start_full_n=0 SHALL be retried every cycle with no ordering between children.
REQ-022 ap_ready SHALL be combinational, asserted in the DISPATCH cycle where (sent | accepted) becomes all ones.
REQ-023 In that same cycle the FSM SHALL clear sent, increment inflight and return to IDLE.
REQ-024 Minimum ap_start-to-ap_ready latency SHALL be 1 cycle (IDLE cycle, then DISPATCH cycle), giving a sustained rate of 1 iteration per 2 cycles.
REQ-025 sink_done with inflight>0 SHALL decrement inflight and assert ap_done on the next cycle.
REQ-026 Issue (ap_ready) and sink_done in the same cycle SHALL leave inflight unchanged, and ap_done still pulses.
REQ-027 sink_done with inflight=0 SHALL leave inflight unchanged, produce no ap_done and set err.
REQ-028 inflight SHALL never exceed MAX_INFLIGHT and never wrap below 0.
REQ-029 ap_start deasserted while in DISPATCH SHALL be ignored: an iteration, once begun, completes.
REQ-030 ap_idle SHALL equal (state==IDLE) & (inflight==0), combinational.

Reset
REQ-031 Reset SHALL force state=IDLE, sent=0, inflight=0, ap_done=0 and err=0, so start_write=0, ap_ready=0, ap_idle=1.
REQ-032 Reset asserted in DISPATCH SHALL abandon the partial iteration; tokens already written are not recalled, and the system-level reset clears the FIFOs.
REQ-033 Reset SHALL have priority over every other event in the same cycle.

Structure
REQ-034 Shared package kernel_bc_start_pkg SHALL hold the FSM state type (IDLE, DISPATCH) and default constants for N_CHILD, MAX_INFLIGHT and CNT_WIDTH.
REQ-035 The inflight counter SHALL be one sub-module, kernel_bc_updown_cnt, with inc/dec inputs, saturating bounds, and a count output.
REQ-036 The start FIFOs SHALL be instantiated outside this block.

Verification
REQ-037 Reset then idle, with N_CHILD=2 -> start_write=00, ap_idle=1, ap_ready=0, err=0.
REQ-038 ap_start=1 with full_n=11 -> start_write=11 in cycle 1, ap_ready pulse in cycle 1, inflight=1, ap_idle=0.
REQ-039 full_n=01 for 3 cycles, then 11 -> child0 written once, child1 strobed 4 cycles, ap_ready on the 4th DISPATCH cycle.
REQ-040 ap_start held with full_n=11 and no sink_done -> exactly 4 ap_ready pulses, then FSM held in IDLE; one sink_done -> ap_done next cycle, and the 5th issue follows.
REQ-041 ap_ready and sink_done in the same cycle at inflight=2 -> inflight stays 2, ap_done pulses once.
REQ-042 sink_done at inflight=0 -> err=1 and stays 1, no ap_done; reset clears err; reset mid-DISPATCH -> start_write=00 next cycle.

Source files
------------

// File: rtl/kernel_bc_start_pkg.sv
// Shared types and default sizing for the start-token dispatcher and its inflight counter.
// No logic, no latency, no backpressure.
// Consumers pull these in with a wildcard import.
package kernel_bc_start_pkg;

    localparam int N_CHILD_DEF      = 2;
    localparam int MAX_INFLIGHT_DEF = 4;
    localparam int CNT_WIDTH_DEF    = 3;

    typedef enum logic {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } state_t;

endpackage

// File: rtl/kernel_bc_start_dispatch_if.sv
// Control bundle between upstream, the start FIFOs and the final process.
// Wires only, no latency.
// Backpressure is carried on start_full_n.
interface kernel_bc_start_dispatch_if
    import kernel_bc_start_pkg::*;
#(
    parameter int N_CHILD = N_CHILD_DEF
);
    logic               ap_start;
    logic               ap_ready;
    logic               ap_done;
    logic               ap_idle;
    logic [N_CHILD-1:0] start_full_n;
    logic [N_CHILD-1:0] start_write;
    logic               start_din;
    logic               sink_done;
    logic               err;

    modport master (
        input  ap_start, start_full_n, sink_done,
        output ap_ready, ap_done, ap_idle, start_write, start_din, err
    );

    modport slave (
        output ap_start, start_full_n, sink_done,
        input  ap_ready, ap_done, ap_idle, start_write, start_din, err
    );
endinterface

// File: rtl/kernel_bc_updown_cnt.sv
// Saturating up/down counter tracking iterations issued but not completed.
// Count updates one cycle after inc/dec; simultaneous inc and dec cancel.
// No backpressure; out-of-range requests are dropped at the bounds.
module kernel_bc_updown_cnt
    import kernel_bc_start_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int MAX_VAL   = MAX_INFLIGHT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count
);
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q < CNT_WIDTH'(MAX_VAL))) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/kernel_bc_start_dispatch.sv
// Broadcasts one start token per iteration to N_CHILD start FIFOs, bounding iterations in flight.
// ap_start to ap_ready in 1 cycle minimum (IDLE then DISPATCH); ap_done registered 1 cycle after sink_done.
// Stalled children retried every cycle; new iterations held off while inflight is at MAX_INFLIGHT.
module kernel_bc_start_dispatch
    import kernel_bc_start_pkg::*;
#(
    parameter int N_CHILD      = N_CHILD_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    kernel_bc_start_dispatch_if.master   bus
);
    state_t               state_q, state_d;
    logic [N_CHILD-1:0]   sent_q, sent_d;
    logic                 ap_done_q, ap_done_d;
    logic                 err_q, err_d;

    logic [N_CHILD-1:0]   start_write;
    logic [N_CHILD-1:0]   accepted;
    logic                 all_sent;
    logic                 ap_ready;
    logic                 dec_ok;
    logic [CNT_WIDTH-1:0] inflight;

    always_comb begin
        start_write = (state_q == DISPATCH) ? ~sent_q : '0;
        accepted    = start_write & bus.start_full_n;
        all_sent    = &(sent_q | accepted);
        ap_ready    = (state_q == DISPATCH) && all_sent;
        // A completion against an empty count is a protocol error, not a decrement.
        dec_ok      = bus.sink_done && (inflight != '0);
        ap_done_d   = dec_ok;
        err_d       = err_q | (bus.sink_done && (inflight == '0));
        state_d     = state_q;
        sent_d      = sent_q;
        if (state_q == IDLE) begin
            if (bus.ap_start && (inflight < CNT_WIDTH'(MAX_INFLIGHT))) begin
                state_d = DISPATCH;
            end
        end else begin
            if (all_sent) begin
                state_d = IDLE;
                sent_d  = '0;
            end else begin
                sent_d  = sent_q | accepted;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sent_q    <= '0;
            ap_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sent_q    <= sent_d;
            ap_done_q <= ap_done_d;
            err_q     <= err_d;
        end
    end

    kernel_bc_updown_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .MAX_VAL   (MAX_INFLIGHT)
    ) u_inflight_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ap_ready),
        .dec   (dec_ok),
        .count (inflight)
    );

    assign bus.start_write = start_write;
    assign bus.start_din   = 1'b1;
    assign bus.ap_ready    = ap_ready;
    assign bus.ap_done     = ap_done_q;
    assign bus.ap_idle     = (state_q == IDLE) && (inflight == '0);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_kernel_bc_start_dispatch.sv
// Directed bench for kernel_bc_start_dispatch with N_CHILD=2, MAX_INFLIGHT=4.
// Inputs change 1ns after the rising edge; outputs are sampled a further 2ns later.
module tb_kernel_bc_start_dispatch;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    kernel_bc_start_dispatch_if #(.N_CHILD(2)) bus ();

    kernel_bc_start_dispatch #(
        .N_CHILD      (2),
        .MAX_INFLIGHT (4),
        .CNT_WIDTH    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        bus.sink_done = 1'b1;
        repeat (n) tick();
        bus.sink_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ap_start = 1'b0;
        bus.start_full_n = 2'b11;
        bus.sink_done = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        #2;
        checks++; if (bus.start_write !== 2'b00) begin errors++; $display("FAIL reset_start_write got %b want 00", bus.start_write); end
        checks++; if (bus.ap_idle !== 1'b1) begin errors++; $display("FAIL reset_ap_idle got %b want 1", bus.ap_idle); end
        checks++; if (bus.ap_ready !== 1'b0) begin errors++; $display("FAIL reset_ap_ready got %b want 0", bus.ap_ready); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        checks++; if (bus.ap_done !== 1'b0) begin errors++; $display("FAIL reset_ap_done got %b want 0", bus.ap_done); end
        checks++; if (bus.start_din !== 1'b1) begin errors++; $display("FAIL reset_start_din got %b want 1", bus.start_din); end
    endtask

    task automatic test_single();
        bus.start_full_n = 2'b11;
        bus.ap_start = 1'b1;
        #2;
        checks++; if (bus.start_write !== 2'b00) begin errors++; $display("FAIL single_idle_write got %b want 00", bus.start_write); end
        tick();
        #2;
        checks++; if (bus.start_write !== 2'b11) begin errors++; $display("FAIL single_dispatch_write got %b want 11", bus.start_write); end
        checks++; if (bus.ap_ready !== 1'b1) begin errors++; $display("FAIL single_ap_ready got %b want 1", bus.ap_ready); end
        bus.ap_start = 1'b0;
        tick();
        #2;
        checks++; if (dut.inflight !== 3'd1) begin errors++; $display("FAIL single_inflight got %0d want 1", dut.inflight); end
        checks++; if (bus.ap_idle !== 1'b0) begin errors++; $display("FAIL single_ap_idle got %b want 0", bus.ap_idle); end
        checks++; if (bus.start_write !== 2'b00) begin errors++; $display("FAIL single_back_idle got %b want 00", bus.start_write); end
        bus.sink_done = 1'b1;
        tick();
        bus.sink_done = 1'b0;
        #2;
        checks++; if (bus.ap_done !== 1'b1) begin errors++; $display("FAIL single_ap_done got %b want 1", bus.ap_done); end
        checks++; if (bus.ap_idle !== 1'b1) begin errors++; $display("FAIL single_idle_after got %b want 1", bus.ap_idle); end
        tick();
        #2;
        checks++; if (bus.ap_done !== 1'b0) begin errors++; $display("FAIL single_ap_done_pulse got %b want 0", bus.ap_done); end
    endtask

    task automatic test_backpressure();
        int acc0;
        int strobe1;
        int ready_at;
        acc0 = 0;
        strobe1 = 0;
        ready_at = 0;
        bus.start_full_n = 2'b01;
        bus.ap_start = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            bus.start_full_n = (k < 4) ? 2'b01 : 2'b11;
            #2;
            if (bus.start_write[0] && bus.start_full_n[0]) acc0++;
            if (bus.start_write[1]) strobe1++;
            if (bus.ap_ready && ready_at == 0) ready_at = k;
            if (k == 2) begin
                checks++; if (bus.start_write !== 2'b10) begin errors++; $display("FAIL bp_retry_write got %b want 10", bus.start_write); end
            end
            if (k == 4) bus.ap_start = 1'b0;
            tick();
        end
        checks++; if (acc0 !== 1) begin errors++; $display("FAIL bp_child0_tokens got %0d want 1", acc0); end
        checks++; if (strobe1 !== 4) begin errors++; $display("FAIL bp_child1_strobes got %0d want 4", strobe1); end
        checks++; if (ready_at !== 4) begin errors++; $display("FAIL bp_ready_cycle got %0d want 4", ready_at); end
        #2;
        checks++; if (dut.inflight !== 3'd1) begin errors++; $display("FAIL bp_inflight got %0d want 1", dut.inflight); end
        drain(1);
    endtask

    task automatic test_max_inflight();
        int readies;
        int found;
        readies = 0;
        found = 0;
        bus.start_full_n = 2'b11;
        bus.ap_start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            #2;
            if (bus.ap_ready) readies++;
        end
        checks++; if (readies !== 4) begin errors++; $display("FAIL max_ready_count got %0d want 4", readies); end
        checks++; if (dut.inflight !== 3'd4) begin errors++; $display("FAIL max_inflight got %0d want 4", dut.inflight); end
        checks++; if (bus.start_write !== 2'b00) begin errors++; $display("FAIL max_held_idle got %b want 00", bus.start_write); end
        bus.sink_done = 1'b1;
        tick();
        bus.sink_done = 1'b0;
        #2;
        checks++; if (bus.ap_done !== 1'b1) begin errors++; $display("FAIL max_ap_done got %b want 1", bus.ap_done); end
        checks++; if (dut.inflight !== 3'd3) begin errors++; $display("FAIL max_after_done got %0d want 3", dut.inflight); end
        for (int c = 0; c < 4 && found == 0; c++) begin
            tick();
            #2;
            if (bus.ap_ready) begin
                found = 1;
                bus.ap_start = 1'b0;
            end
        end
        bus.ap_start = 1'b0;
        checks++; if (found !== 1) begin errors++; $display("FAIL max_fifth_issue got %0d want 1", found); end
        tick();
        #2;
        checks++; if (dut.inflight !== 3'd4) begin errors++; $display("FAIL max_refill got %0d want 4", dut.inflight); end
        drain(4);
        #2;
        checks++; if (dut.inflight !== 3'd0) begin errors++; $display("FAIL max_drained got %0d want 0", dut.inflight); end
    endtask

    task automatic test_back_to_back();
        int readies;
        readies = 0;
        bus.start_full_n = 2'b11;
        bus.ap_start = 1'b1;
        for (int c = 0; c < 10 && readies < 2; c++) begin
            tick();
            #2;
            if (bus.ap_ready) begin
                readies++;
                if (readies == 2) bus.ap_start = 1'b0;
            end
        end
        bus.ap_start = 1'b0;
        tick();
        #2;
        checks++; if (dut.inflight !== 3'd2) begin errors++; $display("FAIL b2b_setup got %0d want 2", dut.inflight); end
        bus.ap_start = 1'b1;
        tick();
        bus.sink_done = 1'b1;
        bus.ap_start = 1'b0;
        #2;
        checks++; if (bus.ap_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", bus.ap_ready); end
        tick();
        bus.sink_done = 1'b0;
        #2;
        checks++; if (dut.inflight !== 3'd2) begin errors++; $display("FAIL b2b_inflight got %0d want 2", dut.inflight); end
        checks++; if (bus.ap_done !== 1'b1) begin errors++; $display("FAIL b2b_ap_done got %b want 1", bus.ap_done); end
        tick();
        #2;
        checks++; if (bus.ap_done !== 1'b0) begin errors++; $display("FAIL b2b_ap_done_once got %b want 0", bus.ap_done); end
        drain(2);
    endtask

    task automatic test_err_and_reset();
        bus.sink_done = 1'b1;
        tick();
        bus.sink_done = 1'b0;
        #2;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", bus.err); end
        checks++; if (bus.ap_done !== 1'b0) begin errors++; $display("FAIL err_no_done got %b want 0", bus.ap_done); end
        checks++; if (dut.inflight !== 3'd0) begin errors++; $display("FAIL err_inflight got %0d want 0", dut.inflight); end
        repeat (3) tick();
        #2;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.err); end
        bus.start_full_n = 2'b00;
        bus.ap_start = 1'b1;
        tick();
        #2;
        checks++; if (bus.start_write !== 2'b11) begin errors++; $display("FAIL rst_mid_write got %b want 11", bus.start_write); end
        reset = 1'b1;
        bus.ap_start = 1'b0;
        tick();
        reset = 1'b0;
        #2;
        checks++; if (bus.start_write !== 2'b00) begin errors++; $display("FAIL rst_mid_abandon got %b want 00", bus.start_write); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err_clear got %b want 0", bus.err); end
        checks++; if (bus.ap_idle !== 1'b1) begin errors++; $display("FAIL rst_ap_idle got %b want 1", bus.ap_idle); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_max_inflight();
        test_back_to_back();
        test_err_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
